// File: rtl/reciprocal_arbiter.sv
// rtl/reciprocal_arbiter.sv - round-robin front end sharing one Q16.16 reciprocal datapath
// Clients get one-hot grants; results return by tag into per-client held slots.
module reciprocal_arbiter #(
  parameter int NB_REQUESTERS = 4,
  parameter int RECIP_LATENCY = 0
) (
  input  logic                          clk,
  input  logic                          reset_ni,
  input  logic [NB_REQUESTERS-1:0]      req_valid_i,
  input  logic [NB_REQUESTERS*32-1:0]   req_x_i,
  output logic [NB_REQUESTERS-1:0]      req_ready_o,
  output logic [NB_REQUESTERS-1:0]      rsp_valid_o,
  output logic [NB_REQUESTERS*32-1:0]   rsp_z_o,
  input  logic [NB_REQUESTERS-1:0]      rsp_ready_i,
  output logic [31:0]                   recip_x_o,
  input  logic [31:0]                   recip_z_i,
  output logic                          busy_o
);
  localparam int N     = NB_REQUESTERS;
  localparam int TW    = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = RECIP_LATENCY + 1;

  logic [TW-1:0] ptr;
  logic [DEPTH-1:0] pipe_valid;
  logic [TW-1:0] pipe_tag [DEPTH];
  logic [31:0] slot [N];

  logic [N-1:0] busy;
  logic [N-1:0] eligible;
  logic [N-1:0] grant;
  logic [TW-1:0] grant_tag;
  logic [TW:0] sum;
  logic accept;
  logic [31:0] sel_x;
  logic capture;
  logic [TW-1:0] cap_tag;
  logic [N-1:0] cap_set;
  logic [N-1:0] rsp_fire;

  // A client stays busy from acceptance until its held result is consumed.
  always_comb begin
    busy = rsp_valid_o;
    for (int s = 0; s < DEPTH; s++) begin
      if (pipe_valid[s]) busy[pipe_tag[s]] = 1'b1;
    end
  end

  assign eligible = req_valid_i & ~busy;

  // Scan offsets from the far end so the client closest to ptr wins last.
  always_comb begin
    grant = '0;
    grant_tag = '0;
    sum = '0;
    for (int off = N - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (TW+1)'(off);
      if (sum >= (TW+1)'(N)) sum = sum - (TW+1)'(N);
      if (eligible[sum[TW-1:0]]) begin
        grant = '0;
        grant[sum[TW-1:0]] = 1'b1;
        grant_tag = sum[TW-1:0];
      end
    end
    if (!reset_ni) begin
      grant = '0;
      grant_tag = '0;
    end
  end

  assign req_ready_o = grant;
  assign accept = |grant;

  always_comb begin
    sel_x = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_x = req_x_i[i*32 +: 32];
    end
  end

  assign capture  = pipe_valid[DEPTH-1];
  assign cap_tag  = pipe_tag[DEPTH-1];
  assign rsp_fire = rsp_valid_o & rsp_ready_i;

  always_comb begin
    cap_set = '0;
    if (capture) cap_set[cap_tag] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr       <= '0;
      recip_x_o <= '0;
    end else if (accept) begin
      ptr       <= (grant_tag == TW'(N - 1)) ? '0 : grant_tag + TW'(1);
      recip_x_o <= sel_x;
    end
  end

  // Tag/valid delay line matching the datapath latency.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      pipe_valid <= '0;
      for (int s = 0; s < DEPTH; s++) pipe_tag[s] <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_tag[0]   <= grant_tag;
      for (int s = 1; s < DEPTH; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_tag[s]   <= pipe_tag[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      rsp_valid_o <= '0;
      for (int i = 0; i < N; i++) slot[i] <= '0;
    end else begin
      rsp_valid_o <= (rsp_valid_o & ~rsp_fire) | cap_set;
      if (capture) slot[cap_tag] <= recip_z_i;
    end
  end

  always_comb begin
    rsp_z_o = '0;
    for (int i = 0; i < N; i++) rsp_z_o[i*32 +: 32] = slot[i];
  end

  assign busy_o = |busy;

  capture_into_empty_slot: assert property (
    @(posedge clk) disable iff (!reset_ni) capture |-> !rsp_valid_o[cap_tag]);

endmodule

// File: tb/tb_reciprocal_arbiter.sv
// tb/tb_reciprocal_arbiter.sv - scoreboard bench for reciprocal_arbiter at latency 0 and 3
// The bench provides the reciprocal datapath model for both instances.
module tb_reciprocal_arbiter;
  localparam int N = 4;
  localparam int LAT1 = 3;

  typedef struct {
    int          dut;
    int          tag;
    logic [31:0] z;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [N-1:0]    req_valid [2];
  logic [N*32-1:0] req_x [2];
  logic [N-1:0]    rsp_ready [2];
  logic [N-1:0]    en [2];
  logic [N-1:0]    outst [2];
  int acc_cnt [2][N];
  int seen [2][N];

  logic [N-1:0]    req_ready0, req_ready1, rsp_valid0, rsp_valid1;
  logic [N*32-1:0] rsp_z0, rsp_z1;
  logic [31:0]     recip_x0, recip_x1, recip_z0, recip_z1, zd1, zd2, zd3;
  logic            busy0, busy1;

  exp_t sbq[$];
  int glog[$];

  function automatic logic [31:0] fz(input logic [31:0] x);
    logic [63:0] q;
    if (x == 32'h0) return 32'h0100_0000;
    q = 64'h0000_0100_0000_0000 / {32'h0, x};
    return q[31:0];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb recip_z0 = fz(recip_x0);
  always @(posedge clk) begin
    zd1 <= fz(recip_x1);
    zd2 <= zd1;
    zd3 <= zd2;
  end
  assign recip_z1 = zd3;

  reciprocal_arbiter #(.NB_REQUESTERS(N), .RECIP_LATENCY(0)) dut0 (
    .clk(clk), .reset_ni(rst_n),
    .req_valid_i(req_valid[0]), .req_x_i(req_x[0]), .req_ready_o(req_ready0),
    .rsp_valid_o(rsp_valid0), .rsp_z_o(rsp_z0), .rsp_ready_i(rsp_ready[0]),
    .recip_x_o(recip_x0), .recip_z_i(recip_z0), .busy_o(busy0));

  reciprocal_arbiter #(.NB_REQUESTERS(N), .RECIP_LATENCY(LAT1)) dut1 (
    .clk(clk), .reset_ni(rst_n),
    .req_valid_i(req_valid[1]), .req_x_i(req_x[1]), .req_ready_o(req_ready1),
    .rsp_valid_o(rsp_valid1), .rsp_z_o(rsp_z1), .rsp_ready_i(rsp_ready[1]),
    .recip_x_o(recip_x1), .recip_z_i(recip_z1), .busy_o(busy1));

  // Scoreboard: push on accept, pop when a result slot fills.
  initial begin
    logic [N-1:0]    prev_rv [2];
    logic [N-1:0]    prev_rr [2];
    logic [N*32-1:0] prev_z [2];
    logic [N-1:0]    rdy, rv;
    logic [N*32-1:0] z;
    logic            bsy;
    int              k;
    exp_t            e;
    for (int d = 0; d < 2; d++) begin
      prev_rv[d] = '0; prev_rr[d] = '0; prev_z[d] = '0; outst[d] = '0;
      for (int i = 0; i < N; i++) acc_cnt[d][i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rdy = (d == 1) ? req_ready1 : req_ready0;
        rv  = (d == 1) ? rsp_valid1 : rsp_valid0;
        z   = (d == 1) ? rsp_z1 : rsp_z0;
        bsy = (d == 1) ? busy1 : busy0;
        if (!rst_n) begin
          prev_rv[d] = '0; prev_rr[d] = '0; outst[d] = '0;
          for (int j = sbq.size() - 1; j >= 0; j--) if (sbq[j].dut == d) sbq.delete(j);
        end else begin
          check_eq($sformatf("grant_onehot%0d", d), 64'($countones(rdy) <= 1), 64'd1);
          check_eq($sformatf("busy_o%0d", d), 64'(bsy), 64'(|outst[d]));
          for (int i = 0; i < N; i++) begin
            if (outst[d][i]) check_eq($sformatf("grant_busy%0d_%0d", d, i), 64'(rdy[i]), 64'd0);
            if (prev_rv[d][i] && !prev_rr[d][i]) begin
              check_eq($sformatf("rsp_held%0d_%0d", d, i), 64'(rv[i]), 64'd1);
              check_eq($sformatf("rsp_stable%0d_%0d", d, i), 64'(z[i*32 +: 32]),
                       64'(prev_z[d][i*32 +: 32]));
            end
            if (rv[i] && !prev_rv[d][i]) begin
              k = -1;
              for (int j = 0; j < sbq.size(); j++) if (k < 0 && sbq[j].dut == d) k = j;
              if (k < 0) begin
                check_eq($sformatf("rsp_unexpected%0d_%0d", d, i), 64'd1, 64'd0);
              end else begin
                e = sbq[k];
                sbq.delete(k);
                check_eq($sformatf("rsp_tag%0d", d), 64'(i), 64'(e.tag));
                check_eq($sformatf("rsp_z%0d_%0d", d, i), 64'(z[i*32 +: 32]), 64'(e.z));
                check_eq($sformatf("rsp_lat%0d_%0d", d, i), 64'(cyc),
                         64'(e.cyc + 2 + ((d == 1) ? LAT1 : 0)));
              end
            end
            if (rv[i] && rsp_ready[d][i]) outst[d][i] = 1'b0;
            if (req_valid[d][i] && rdy[i]) begin
              sbq.push_back('{dut: d, tag: i, z: fz(req_x[d][i*32 +: 32]), cyc: cyc});
              outst[d][i] = 1'b1;
              acc_cnt[d][i]++;
              if (d == 0) glog.push_back(i);
            end
          end
          prev_rv[d] = rv;
          prev_rr[d] = rsp_ready[d];
          prev_z[d]  = z;
        end
      end
    end
  end

  // Each tick starts a new cycle; accepted clients present a fresh operand.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          if (acc_cnt[d][i] != seen[d][i]) begin
            seen[d][i] = acc_cnt[d][i];
            req_x[d][i*32 +: 32] = $urandom_range(32'h00FF_FFFF, 32'h0001_0000);
          end
          req_valid[d][i] = en[d][i];
        end
      end
      #1;
    end
  endtask

  task automatic do_reset();
    for (int d = 0; d < 2; d++) begin
      en[d] = '0; req_valid[d] = '0; rsp_ready[d] = '0;
    end
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain();
    int k;
    for (int d = 0; d < 2; d++) begin
      en[d] = '0; rsp_ready[d] = '1;
    end
    tick(2);
    k = 0;
    while ((busy0 || busy1 || sbq.size() != 0) && k < 40) begin
      tick();
      k++;
    end
    check_eq("drain_idle", {62'd0, busy0, busy1}, 64'd0);
    check_eq("drain_sb", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    int gs;
    int exp2 [6] = '{0, 1, 2, 3, 0, 1};
    int exp3 [12] = '{0, 1, 2, 3, 0, 2, 3, 0, 2, 3, 0, 1};
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d] = '0; rsp_ready[d] = '0; req_valid[d] = '1;
      req_x[d] = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
      for (int i = 0; i < N; i++) seen[d][i] = 0;
    end
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_ready0", 64'(req_ready0), 64'd0);
    check_eq("rst_ready1", 64'(req_ready1), 64'd0);
    check_eq("rst_rsp_valid", {56'd0, rsp_valid1, rsp_valid0}, 64'd0);
    check_eq("rst_rsp_z", 64'(rsp_z0 | rsp_z1), 64'd0);
    check_eq("rst_recip_x", {recip_x1, recip_x0}, 64'd0);
    check_eq("rst_busy", {62'd0, busy1, busy0}, 64'd0);

    // Single operation, latency 0.
    do_reset();
    req_x[0][31:0] = 32'h0002_0000;
    en[0] = 4'b0001;
    tick();
    check_eq("t1_grant_c0", 64'(req_ready0), 64'h1);
    en[0] = '0;
    tick();
    check_eq("t1_recip_x_c1", 64'(recip_x0), 64'h0002_0000);
    check_eq("t1_no_grant_c1", 64'(req_ready0), 64'h0);
    tick();
    check_eq("t1_rsp_valid_c2", 64'(rsp_valid0), 64'h1);
    check_eq("t1_rsp_z_c2", 64'(rsp_z0[31:0]), 64'h0080_0000);
    tick(3);
    check_eq("t1_rsp_hold", 64'(rsp_z0[31:0]), 64'h0080_0000);
    drain();

    // All clients continuously valid, responses consumed at once.
    do_reset();
    rsp_ready[0] = '1;
    gs = glog.size();
    en[0] = '1;
    tick(6);
    en[0] = '0;
    tick();
    check_eq("t2_grant_count", 64'(glog.size() - gs), 64'd6);
    for (int k = 0; k < 6; k++)
      if (gs + k < glog.size()) check_eq($sformatf("t2_grant%0d", k), 64'(glog[gs+k]), 64'(exp2[k]));
    drain();

    // Client 1 holds its result for ten cycles, then is regranted the cycle after.
    do_reset();
    rsp_ready[0] = 4'b1101;
    gs = glog.size();
    en[0] = '1;
    tick(10);
    tick();
    rsp_ready[0] = '1;
    check_eq("t3_held_c10", 64'(rsp_valid0[1]), 64'd1);
    check_eq("t3_no_regrant_c10", 64'(req_ready0[1]), 64'd0);
    tick();
    check_eq("t3_regrant_c11", 64'(req_ready0), 64'h2);
    en[0] = '0;
    tick();
    check_eq("t3_grant_count", 64'(glog.size() - gs), 64'd12);
    for (int k = 0; k < 12; k++)
      if (gs + k < glog.size()) check_eq($sformatf("t3_grant%0d", k), 64'(glog[gs+k]), 64'(exp3[k]));
    drain();

    // Latency 3, four back-to-back accepts.
    do_reset();
    req_x[1] = {32'h0003_0000, 32'h0004_0000, 32'h0002_0000, 32'h0001_0000};
    rsp_ready[1] = '1;
    en[1] = '1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq($sformatf("t4_grant_c%0d", c), 64'(req_ready1), 64'(1 << c));
    end
    en[1] = '0;
    tick();
    check_eq("t4_rsp_c4", 64'(rsp_valid1), 64'h0);
    for (int c = 5; c < 9; c++) begin
      tick();
      check_eq($sformatf("t4_rsp_c%0d", c), 64'(rsp_valid1), 64'(1 << (c - 5)));
    end
    check_eq("t4_z3", 64'(rsp_z1[127:96]), 64'h0055_5555);
    drain();

    // Reset while two operations are in flight.
    do_reset();
    en[0] = '1;
    tick(3);
    rst_n = 1'b0;
    #1;
    check_eq("t5_ready", 64'(req_ready0), 64'h0);
    check_eq("t5_rsp_valid", 64'(rsp_valid0), 64'h0);
    check_eq("t5_rsp_z", 64'(rsp_z0), 64'h0);
    check_eq("t5_recip_x", 64'(recip_x0), 64'h0);
    check_eq("t5_busy", 64'(busy0), 64'h0);
    tick(2);
    rst_n = 1'b1;
    rsp_ready[0] = '1;
    #1;
    check_eq("t5_first_grant", 64'(req_ready0), 64'h1);
    check_eq("t5_no_stale", 64'(rsp_valid0), 64'h0);
    tick(3);
    drain();

    // Pointer continues after client 2; x=0 passes through to the datapath.
    do_reset();
    rsp_ready[0] = '1;
    en[0] = 4'b0100;
    tick();
    check_eq("t6_grant2", 64'(req_ready0), 64'h4);
    en[0] = 4'b1001;
    req_x[0][127:96] = 32'h0;
    tick();
    check_eq("t6_grant3", 64'(req_ready0), 64'h8);
    tick();
    check_eq("t6_grant0", 64'(req_ready0), 64'h1);
    en[0] = '0;
    tick();
    check_eq("t6_rsp3_valid", 64'(rsp_valid0[3]), 64'd1);
    check_eq("t6_rsp3_zero_x", 64'(rsp_z0[127:96]), 64'h0100_0000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
